// File: rtl/bs_sic_tpg.sv
// -----------------------------------------------------------------------------
// bs_sic_tpg
// BIST test-pattern generator. It sits between the BIST controller and the CUT
// input scan/boundary register. The pattern mode is chosen at run time:
//   00 plain LFSR, 01 bit-swapping LFSR, 10 single-input-change (SIC),
//   11 bit-swapping LFSR combined with SIC.
// Each start emits a programmed number of patterns, then pulses o_done once.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      pulse that loads seed/mode/count and begins a run (ignored while busy)
//   i_mode[1:0]  pattern mode, sampled at start
//   i_seed_in    LFSR seed, sampled at start; all-zero substitutes SEED
//   i_num_pat    patterns per run, sampled at start; 0 means 2^CW
//   i_en         advance enable while running
//   o_pattern    current test pattern (registered)
//   o_pat_valid  o_pattern carries a new pattern this cycle
//   o_busy       run in progress
//   o_done       one-cycle pulse after the last pattern
//   o_state      FSM state (0 IDLE, 1 RUN, 2 DONE), debug visibility
// Optional MISR (macro TPG_MISR_EN):
//   i_resp_in, i_resp_valid  CUT response compacted into o_signature
//   o_signature              MISR signature, stable once o_done pulses
//
// Handshake: a pattern is transferred on each cycle in which o_pat_valid is
// high; there is no back-pressure, and i_en only stalls generation.
// -----------------------------------------------------------------------------
module bs_sic_tpg #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
    parameter logic [WIDTH-1:0] SEED  = 5'b00001,
    parameter int               CW    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_seed_in,
    input  logic [CW-1:0]    i_num_pat,
    input  logic             i_en,
`ifdef TPG_MISR_EN
    input  logic [WIDTH-1:0] i_resp_in,
    input  logic             i_resp_valid,
    output logic [WIDTH-1:0] o_signature,
`endif
    output logic [WIDTH-1:0] o_pattern,
    output logic             o_pat_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last Johnson state before wrap: 100..0. The LFSR advances on this step.
    localparam logic [WIDTH-1:0] J_LAST = {1'b1, {(WIDTH-1){1'b0}}};

    // Bit swap: when the MSB is set, exchange each pair (2i+1, 2i) below the MSB.
    function automatic logic [WIDTH-1:0] f_bs(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        if (v[WIDTH-1]) begin
            for (int i = 0; 2 * i + 1 <= WIDTH - 2; i++) begin
                r[2*i]   = v[2*i+1];
                r[2*i+1] = v[2*i];
            end
        end
        return r;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_s, w_s_nxt;
    logic [WIDTH-1:0] r_j, w_j_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [CW-1:0]    r_num_pat, w_num_pat_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_pattern, w_pattern_nxt;
    logic             r_pat_valid, w_pat_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_s_adv;
    logic [WIDTH-1:0] w_j_adv;
    logic [WIDTH-1:0] w_f;
    logic [CW-1:0]    w_count_inc;
    logic             w_start_ok;

    assign w_s_adv     = {r_s[WIDTH-2:0], ^(r_s & TAPS)};
    assign w_j_adv     = {r_j[WIDTH-2:0], ~r_j[WIDTH-1]};
    // CW-bit wrap makes num_pat = 0 terminate after exactly 2^CW patterns.
    assign w_count_inc = r_count + 1'b1;
    assign w_start_ok  = (r_state == IDLE) && i_start;

    always_comb begin
        w_f = r_s;
        case (r_mode)
            2'b00:   w_f = r_s;
            2'b01:   w_f = f_bs(r_s);
            2'b10:   w_f = r_s ^ r_j;
            default: w_f = f_bs(r_s) ^ r_j;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_j_nxt         = r_j;
        w_count_nxt     = r_count;
        w_num_pat_nxt   = r_num_pat;
        w_mode_nxt      = r_mode;
        w_pattern_nxt   = r_pattern;
        w_pat_valid_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_s_nxt       = (i_seed_in == '0) ? SEED : i_seed_in;
                    w_j_nxt       = '0;
                    w_count_nxt   = '0;
                    w_num_pat_nxt = i_num_pat;
                    w_mode_nxt    = i_mode;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = RUN;
                end
            end
            RUN: begin
                if (i_en) begin
                    w_pattern_nxt   = w_f;
                    w_pat_valid_nxt = 1'b1;
                    w_count_nxt     = w_count_inc;
                    if (r_mode[1]) begin
                        // SIC: walk the Johnson counter, reseed once per period.
                        w_j_nxt = w_j_adv;
                        if (r_j == J_LAST) w_s_nxt = w_s_adv;
                    end else begin
                        w_s_nxt = w_s_adv;
                    end
                    if (w_count_inc == r_num_pat) w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_s         <= SEED;
            r_j         <= '0;
            r_count     <= '0;
            r_num_pat   <= '0;
            r_mode      <= 2'b00;
            r_pattern   <= '0;
            r_pat_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_j         <= w_j_nxt;
            r_count     <= w_count_nxt;
            r_num_pat   <= w_num_pat_nxt;
            r_mode      <= w_mode_nxt;
            r_pattern   <= w_pattern_nxt;
            r_pat_valid <= w_pat_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef TPG_MISR_EN
    logic [WIDTH-1:0] r_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else if (w_start_ok) begin
            r_sig <= '0;
        end else if (i_resp_valid) begin
            r_sig <= {r_sig[WIDTH-2:0], ^(r_sig & TAPS)} ^ i_resp_in;
        end
    end

    assign o_signature = r_sig;
`else
    // Only the MISR uses the start-accept qualifier.
    logic w_unused;
    assign w_unused = w_start_ok;
`endif

    assign o_pattern   = r_pattern;
    assign o_pat_valid = r_pat_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_state     = r_state;

endmodule

// File: tb/tb_bs_sic_tpg.sv
module tb_bs_sic_tpg;

  localparam int W  = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  seed_in = '0;
  logic [CW-1:0] num_pat = '0;
  logic          en = 1'b0;
  logic [W-1:0]  pattern;
  logic          pat_valid;
  logic          busy;
  logic          done;
  logic [1:0]    state;
`ifdef TPG_MISR_EN
  logic [W-1:0]  resp_in = '0;
  logic          resp_valid = 1'b0;
  logic [W-1:0]  signature;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  bs_sic_tpg dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_mode      (mode),
    .i_seed_in   (seed_in),
    .i_num_pat   (num_pat),
    .i_en        (en),
`ifdef TPG_MISR_EN
    .i_resp_in   (resp_in),
    .i_resp_valid(resp_valid),
    .o_signature (signature),
`endif
    .o_pattern   (pattern),
    .o_pat_valid (pat_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_state     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: issue one start, leave start low afterwards
  task automatic do_start(input logic [1:0] m, input logic [W-1:0] sd, input logic [CW-1:0] n);
    mode = m;
    seed_in = sd;
    num_pat = n;
    en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("pv_low_after_start", pat_valid, 0);
  endtask

  // scoreboard: drain exp_q one pattern per cycle, then expect the done pulse
  task automatic expect_run(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      chk({tag, "_pv"}, pat_valid, 1);
      chk({tag, "_pat"}, pattern, e);
      chk({tag, "_nodone"}, done, 0);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_pv_drop"}, pat_valid, 0);
    chk({tag, "_pat_hold"}, pattern, e);
    tick();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle"}, state, 0);
  endtask

  initial begin
    int n_pv;
    bit seen;
    logic [W-1:0] last;

    // reset state
    #12;
    chk("rst_pattern", pattern, 0);
    chk("rst_pv", pat_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    tick();

    // plain LFSR
    exp_q = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    do_start(2'b00, 5'b00001, 16'd6);
    expect_run("lfsr");

    // bit-swapping LFSR
    exp_q = '{5'b01001, 5'b10001};
    do_start(2'b01, 5'b01001, 16'd2);
    expect_run("bs");

    // SIC, spans one Johnson wrap and the reseed
    exp_q = '{5'b00001, 5'b00000, 5'b00010, 5'b00110, 5'b01110, 5'b11110,
              5'b11111, 5'b11101, 5'b11001, 5'b10001, 5'b00010};
    do_start(2'b10, 5'b00001, 16'd11);
    expect_run("sic");

    // BS-SIC
    exp_q = '{5'b01001, 5'b01000, 5'b01010};
    do_start(2'b11, 5'b01001, 16'd3);
    expect_run("bssic");

    // zero seed substitutes SEED
    exp_q = '{5'b00001};
    do_start(2'b00, 5'b00000, 16'd1);
    expect_run("zseed");

    // en stalls; start and input changes while busy have no effect
    do_start(2'b00, 5'b00001, 16'd3);
    tick();
    chk("en1_pv", pat_valid, 1);
    chk("en1_pat", pattern, 5'b00001);
    en = 1'b0;
    start = 1'b1;
    mode = 2'b10;
    seed_in = 5'b10101;
    num_pat = 16'd1;
    tick();
    chk("en0a_pv", pat_valid, 0);
    chk("en0a_pat", pattern, 5'b00001);
    start = 1'b0;
    tick();
    chk("en0b_pv", pat_valid, 0);
    chk("en0b_pat", pattern, 5'b00001);
    chk("en0b_busy", busy, 1);
    en = 1'b1;
    exp_q = '{5'b00010, 5'b00100};
    expect_run("en_resume");

    // start coincident with the last pattern, and during DONE, is ignored
    do_start(2'b00, 5'b00001, 16'd2);
    tick();
    chk("coll_p1", pattern, 5'b00001);
    start = 1'b1;
    tick();
    chk("coll_p2", pattern, 5'b00010);
    tick();
    chk("coll_done", done, 1);
    chk("coll_busy", busy, 0);
    start = 1'b0;
    tick();
    chk("coll_idle", state, 0);
    chk("coll_not_restarted", busy, 0);

    // reset mid-run
    do_start(2'b00, 5'b00111, 16'd10);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_pattern", pattern, 0);
    chk("mrst_pv", pat_valid, 0);
    chk("mrst_state", state, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("mrst_no_done", seen, 0);

    // num_pat 0 means 2^16 patterns; last pattern is s_65535 = s_1 (period 31)
    do_start(2'b00, 5'b00001, 16'd0);
    n_pv = 0;
    seen = 1'b0;
    last = '0;
    for (int c = 0; c < 70000 && !seen; c++) begin
      tick();
      if (pat_valid) begin
        n_pv++;
        last = pattern;
      end
      if (done) seen = 1'b1;
    end
    chk("full_done_seen", seen, 1);
    chk("full_count", n_pv, 65536);
    chk("full_last", last, 5'b00010);

`ifdef TPG_MISR_EN
    // MISR: start clears, then 00001 once, 00000 three times
    do_start(2'b00, 5'b00001, 16'd8);
    chk("misr_clear", signature, 0);
    resp_valid = 1'b1;
    resp_in = 5'b00001;
    tick();
    chk("misr_1", signature, 5'b00001);
    resp_in = 5'b00000;
    tick();
    chk("misr_2", signature, 5'b00010);
    tick();
    chk("misr_3", signature, 5'b00100);
    tick();
    chk("misr_4", signature, 5'b01001);
    resp_valid = 1'b0;
    tick();
    chk("misr_hold", signature, 5'b01001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
